// File: rtl/fetch_align_ctrl.sv
// Instruction fetch sequencer for an RV32IC front end: word-aligned memory reads,
// halfword-aligned instruction extraction, and a one-halfword carry buffer.
module fetch_align_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_compressed
);

    typedef enum logic [1:0] {IDLE, REQ, OUT, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, pc_n;
    logic [15:0] half_buf, hb_n;
    logic        half_valid, hv_n;
    logic [31:0] addr_n, instr_n, ipc_n;
    logic        iv_n, ic_n;
    logic        new_txn;

    function automatic logic is_full(input logic [1:0] lo);
        return lo == 2'b11;
    endfunction

    assign imem_read = (state == REQ) || (state == DRAIN);

    always_comb begin
        state_n = state;
        pc_n    = fetch_pc;
        hb_n    = half_buf;
        hv_n    = half_valid;
        iv_n    = instr_valid;
        instr_n = instr;
        ipc_n   = instr_pc;
        ic_n    = instr_compressed;
        new_txn = 1'b0;
        if (redirect) begin
            // A read already on the bus cannot be cancelled, so its data is drained.
            pc_n = redirect_pc & ~32'd1;
            hv_n = 1'b0;
            iv_n = 1'b0;
            if ((state == REQ || state == DRAIN) && !imem_resp) begin
                state_n = DRAIN;
            end else begin
                state_n = REQ;
                new_txn = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_n = REQ;
                    new_txn = 1'b1;
                end
                REQ: begin
                    if (imem_resp) begin
                        ipc_n = fetch_pc;
                        if (half_valid) begin
                            instr_n = {imem_rdata[15:0], half_buf};
                            ic_n    = 1'b0;
                            hb_n    = imem_rdata[31:16];
                            pc_n    = fetch_pc + 32'd4;
                            iv_n    = 1'b1;
                            state_n = OUT;
                        end else if (!fetch_pc[1]) begin
                            iv_n    = 1'b1;
                            state_n = OUT;
                            if (!is_full(imem_rdata[1:0])) begin
                                instr_n = {16'h0000, imem_rdata[15:0]};
                                ic_n    = 1'b1;
                                hb_n    = imem_rdata[31:16];
                                hv_n    = 1'b1;
                                pc_n    = fetch_pc + 32'd2;
                            end else begin
                                instr_n = imem_rdata;
                                ic_n    = 1'b0;
                                pc_n    = fetch_pc + 32'd4;
                            end
                        end else if (!is_full(imem_rdata[17:16])) begin
                            instr_n = {16'h0000, imem_rdata[31:16]};
                            ic_n    = 1'b1;
                            pc_n    = fetch_pc + 32'd2;
                            iv_n    = 1'b1;
                            state_n = OUT;
                        end else begin
                            // Lower half of a straddling 32-bit instruction: fetch the next word.
                            hb_n    = imem_rdata[31:16];
                            hv_n    = 1'b1;
                            new_txn = 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (instr_ready) begin
                        if (half_valid && !is_full(half_buf[1:0])) begin
                            instr_n = {16'h0000, half_buf};
                            ipc_n   = fetch_pc;
                            ic_n    = 1'b1;
                            pc_n    = fetch_pc + 32'd2;
                            hv_n    = 1'b0;
                            iv_n    = 1'b1;
                        end else begin
                            iv_n    = 1'b0;
                            state_n = REQ;
                            new_txn = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_resp) begin
                        state_n = REQ;
                        new_txn = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        addr_n = imem_address;
        if (new_txn) begin
            addr_n = {pc_n[31:2], 2'b00} + (hv_n ? 32'd4 : 32'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            fetch_pc         <= RESET_PC & ~32'd1;
            half_buf         <= '0;
            half_valid       <= 1'b0;
            imem_address     <= '0;
            instr_valid      <= 1'b0;
            instr            <= '0;
            instr_pc         <= '0;
            instr_compressed <= 1'b0;
        end else begin
            state            <= state_n;
            fetch_pc         <= pc_n;
            half_buf         <= hb_n;
            half_valid       <= hv_n;
            imem_address     <= addr_n;
            instr_valid      <= iv_n;
            instr            <= instr_n;
            instr_pc         <= ipc_n;
            instr_compressed <= ic_n;
        end
    end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Bench for fetch_align_ctrl: memory responder, instruction-stream reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_align_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_compressed;

    fetch_align_ctrl #(.RESET_PC(32'h00000060)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_read(imem_read), .imem_address(imem_address), .imem_rdata(imem_rdata),
        .imem_resp(imem_resp), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_compressed(instr_compressed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {logic [31:0] i; logic [31:0] pc; logic c;} acc_t;
    acc_t        acc_q[$];
    logic [31:0] reads_q[$];
    int          reads_acc_q[$];

    logic [31:0] ovr[logic [31:0]];
    logic [31:0] seed = 32'h1234_5678;
    int          lat_fix = 1;
    int          wait_left = 0;
    bit          busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] x;
        if (ovr.exists(a)) return ovr[a];
        x = (a ^ seed) * 32'h9E3779B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EBCA6B;
        x = x ^ (x >> 13);
        return x;
    endfunction

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // {compressed, instruction} that must appear at a given PC
    function automatic logic [32:0] expect_at(input logic [31:0] pc);
        logic [15:0] h0, h1;
        h0 = half_at(pc);
        if (h0[1:0] != 2'b11) return {1'b1, 16'h0000, h0};
        h1 = half_at(pc + 32'd2);
        return {1'b0, h1, h0};
    endfunction

    function automatic logic [31:0] rd(input int k);
        return (reads_q.size() > k) ? reads_q[k] : 32'hDEAD_BEEF;
    endfunction

    function automatic int rd_acc(input int k);
        return (reads_acc_q.size() > k) ? reads_acc_q[k] : -1;
    endfunction

    function automatic acc_t ac(input int k);
        acc_t z;
        z.i = 32'hDEAD_BEEF; z.pc = 32'hDEAD_BEEF; z.c = 1'bx;
        return (acc_q.size() > k) ? acc_q[k] : z;
    endfunction

    // Compare process: reference stream model checked on every cycle
    logic [31:0] m_pc = 32'h60;
    logic        prev_read = 0, prev_resp = 0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        logic [32:0] e;
        acc_t a;
        if (rst) begin
            chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
            chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_imem_address", imem_address, 32'd0);
            m_pc = 32'h60;
            prev_read = 0;
            prev_resp = 0;
        end else begin
            e = expect_at(m_pc);
            if (instr_valid) begin
                chk("instr", instr, e[31:0]);
                chk("instr_pc", instr_pc, m_pc);
                chk("instr_compressed", {31'd0, instr_compressed}, {31'd0, e[32]});
            end
            if (imem_read) begin
                chk("addr_align", {30'd0, imem_address[1:0]}, 32'd0);
                if (prev_read && !prev_resp) begin
                    chk("addr_hold", imem_address, prev_addr);
                end else begin
                    reads_q.push_back(imem_address);
                    reads_acc_q.push_back(acc_q.size());
                end
            end
            if (instr_valid && instr_ready && !redirect) begin
                a.i = instr; a.pc = instr_pc; a.c = instr_compressed;
                acc_q.push_back(a);
                m_pc = m_pc + (e[32] ? 32'd2 : 32'd4);
            end
            if (redirect) m_pc = redirect_pc & ~32'd1;
            prev_read = imem_read;
            prev_resp = imem_resp;
            prev_addr = imem_address;
        end
    end

    // One clock cycle; the memory responder updates its outputs here
    task automatic tick();
        @(posedge clk);
        #2;
        imem_resp = 1'b0;
        imem_rdata = $urandom;
        if (rst || !imem_read) begin
            busy = 0;
        end else begin
            if (!busy) begin
                busy = 1;
                wait_left = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
            end
            if (wait_left == 0) begin
                imem_resp = 1'b1;
                imem_rdata = mem_word(imem_address);
                busy = 0;
            end else begin
                wait_left--;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        instr_ready = 1'b1;
        tick();
        tick();
        acc_q.delete();
        reads_q.delete();
        reads_acc_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_acc(input int n, input string name);
        for (int k = 0; k < 300; k++) begin
            if (acc_q.size() >= n) break;
            tick();
        end
        if (acc_q.size() < n) chk(name, acc_q.size(), n);
    endtask

    initial begin
        acc_t a;
        // 1: single 32-bit instruction
        ovr.delete();
        ovr[32'h60] = 32'h00A00093;
        do_reset();
        wait_acc(2, "t1_timeout");
        a = ac(0);
        chk("t1_instr", a.i, 32'h00A00093);
        chk("t1_pc", a.pc, 32'h60);
        chk("t1_comp", {31'd0, a.c}, 32'd0);
        chk("t1_read0", rd(0), 32'h60);
        chk("t1_read1", rd(1), 32'h64);
        chk("t1_read1_after", rd_acc(1), 1);

        // 2: two compressed instructions from one read
        ovr.delete();
        ovr[32'h60] = 32'h00014501;
        do_reset();
        wait_acc(3, "t2_timeout");
        a = ac(0);
        chk("t2_i0", a.i, 32'h00004501);
        chk("t2_pc0", a.pc, 32'h60);
        chk("t2_c0", {31'd0, a.c}, 32'd1);
        a = ac(1);
        chk("t2_i1", a.i, 32'h00000001);
        chk("t2_pc1", a.pc, 32'h62);
        chk("t2_c1", {31'd0, a.c}, 32'd1);
        chk("t2_read1", rd(1), 32'h64);
        chk("t2_one_read", rd_acc(1), 2);

        // 3: straddling 32-bit instruction, buffered compressed with no extra read
        ovr.delete();
        ovr[32'h60] = 32'h00934501;
        ovr[32'h64] = 32'h123400A0;
        do_reset();
        wait_acc(4, "t3_timeout");
        a = ac(0);
        chk("t3_i0", a.i, 32'h00004501);
        a = ac(1);
        chk("t3_i1", a.i, 32'h00A00093);
        chk("t3_pc1", a.pc, 32'h62);
        chk("t3_c1", {31'd0, a.c}, 32'd0);
        a = ac(2);
        chk("t3_i2", a.i, 32'h00001234);
        chk("t3_pc2", a.pc, 32'h66);
        chk("t3_c2", {31'd0, a.c}, 32'd1);
        chk("t3_read1", rd(1), 32'h64);
        chk("t3_read2", rd(2), 32'h68);
        chk("t3_read2_after", rd_acc(2), 3);

        // 4: redirect during a pending read drains it
        ovr.delete();
        ovr[32'h60] = 32'h00A00093;
        ovr[32'h64] = 32'h22222222;
        ovr[32'h100] = 32'h45050001;
        lat_fix = 1;
        do_reset();
        wait_acc(1, "t4_timeout");
        lat_fix = 30;
        wait_left = 30;
        chk("t4_pending_read", {31'd0, imem_read}, 32'd1);
        chk("t4_pending_addr", imem_address, 32'h64);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_drain_read", {31'd0, imem_read}, 32'd1);
        chk("t4_drain_addr", imem_address, 32'h64);
        lat_fix = 1;
        wait_left = 0;
        wait_acc(2, "t4_timeout2");
        chk("t4_read2", rd(2), 32'h100);
        a = ac(1);
        chk("t4_instr", a.i, 32'h00004505);
        chk("t4_pc", a.pc, 32'h102);
        chk("t4_comp", {31'd0, a.c}, 32'd1);

        // 5: decode stall holds outputs
        ovr.delete();
        ovr[32'h60] = 32'h00A00093;
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (instr_valid) break;
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            chk("t5_valid", {31'd0, instr_valid}, 32'd1);
            chk("t5_instr", instr, 32'h00A00093);
            chk("t5_pc", instr_pc, 32'h60);
            chk("t5_no_read", {31'd0, imem_read}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;

        // 6: asynchronous reset in the middle of a read
        ovr.delete();
        lat_fix = 20;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (imem_read) break;
            tick();
        end
        chk("t6_read_before", {31'd0, imem_read}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_read", {31'd0, imem_read}, 32'd0);
        chk("t6_async_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_async_addr", imem_address, 32'd0);
        tick();
        acc_q.delete();
        reads_q.delete();
        reads_acc_q.delete();
        rst = 1'b0;
        chk("t6_idle_read", {31'd0, imem_read}, 32'd0);
        imem_resp = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        lat_fix = 1;
        tick();
        chk("t6_first_read", {31'd0, imem_read}, 32'd1);
        chk("t6_first_addr", imem_address, 32'h60);
        wait_acc(1, "t6_timeout");
        a = ac(0);
        chk("t6_pc", a.pc, 32'h60);

        // Randomized traffic: random latency, stalls and redirects (including wrap region)
        ovr.delete();
        seed = $urandom;
        lat_fix = -1;
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            instr_ready = ($urandom % 4) != 0;
            redirect = ($urandom % 24) == 0;
            case ($urandom % 4)
                0, 1: redirect_pc = $urandom & 32'h0000_03FF;
                2: redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
                default: redirect_pc = $urandom;
            endcase
            tick();
        end
        redirect = 1'b0;
        if (acc_q.size() < 300) chk("rand_progress", acc_q.size(), 300);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
